// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between fetch and load/store; 0-cycle grant, 1-cycle read data, no response backpressure.
// Optional IMEM_ARB_RR_EN selects round-robin on contention (default: data wins ties).
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_IDX_W  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  input  logic                    fetch_flush,
  output logic                    fetch_gnt,
  output logic                    fetch_rvalid,
  output logic [DATA_WIDTH-1:0]   fetch_rdata,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_gnt,
  output logic                    data_rvalid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [MEM_IDX_W-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  typedef struct packed {
    logic                  en;
    logic [STRB_W-1:0]     we;
    logic [MEM_IDX_W-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  owner_t                pend;
  logic [DATA_WIDTH-1:0] fetch_hold;
  logic [DATA_WIDTH-1:0] data_hold;
  logic                  fetch_ok;
  logic                  pick_fetch;
  logic                  grant_f;
  logic                  grant_d;
  mem_req_t              mreq;

  assign fetch_ok = fetch_req & ~fetch_flush;

`ifdef IMEM_ARB_RR_EN
  logic last_data;

  // On a tie the requester that did not win last time goes first.
  assign pick_fetch = fetch_ok & (~data_req | last_data);
`else
  assign pick_fetch = fetch_ok & ~data_req;
`endif

  // Gating with rst keeps the port quiet while reset is held, even with live requests.
  assign grant_f = rst & pick_fetch;
  assign grant_d = rst & data_req & ~pick_fetch;

  always_comb begin
    mreq = '0;
    if (grant_f) begin
      mreq.en   = 1'b1;
      mreq.addr = fetch_addr[MEM_IDX_W+1:2];
    end else if (grant_d) begin
      mreq.en    = 1'b1;
      mreq.addr  = data_addr[MEM_IDX_W+1:2];
      mreq.we    = data_we ? data_wstrb : '0;
      mreq.wdata = data_wdata;
    end
  end

  assign fetch_gnt = grant_f;
  assign data_gnt  = grant_d;
  assign mem_en    = mreq.en;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

  assign fetch_rvalid = (pend == OWN_FETCH) & ~fetch_flush;
  assign data_rvalid  = (pend == OWN_DATA);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : fetch_hold;
  assign data_rdata   = data_rvalid ? mem_rdata : data_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= OWN_NONE;
      fetch_hold <= '0;
      data_hold  <= '0;
`ifdef IMEM_ARB_RR_EN
      last_data  <= 1'b1;
`endif
    end else begin
      if (grant_f)
        pend <= OWN_FETCH;
      else if (grant_d && !data_we)
        pend <= OWN_DATA;
      else
        pend <= OWN_NONE;

      if (fetch_rvalid)
        fetch_hold <= mem_rdata;
      if (data_rvalid)
        data_hold <= mem_rdata;
`ifdef IMEM_ARB_RR_EN
      if (grant_f || grant_d)
        last_data <= grant_d;
`endif
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[ADDR_WIDTH-1:MEM_IDX_W+2], fetch_addr[1:0],
                              data_addr[ADDR_WIDTH-1:MEM_IDX_W+2], data_addr[1:0]};

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed table-driven bench for imem_port_arbiter with a small one-cycle-latency memory model.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int nerr   = 0;
  int ncheck = 0;

  imem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word i starts as 0xA500_0000 | i.
  logic [31:0] mem [0:32767];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 32'hA500_0000 | i;
      mem_init <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        freq;
    logic [31:0] faddr;
    logic        fflush;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic        fgnt;
    logic        dgnt;
    logic        men;
    logic [14:0] maddr;
    logic [3:0]  mwe;
    logic        frv;
    logic [31:0] frd;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  function automatic vec_t mk(
    input logic freq, input logic [31:0] faddr, input logic fflush,
    input logic dreq, input logic dwe, input logic [31:0] daddr,
    input logic [31:0] dwdata, input logic [3:0] dstrb,
    input logic fgnt, input logic dgnt, input logic men,
    input logic [14:0] maddr, input logic [3:0] mwe,
    input logic frv, input logic [31:0] frd, input logic drv, input logic [31:0] drd);
    vec_t v;
    v.freq = freq; v.faddr = faddr; v.fflush = fflush;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata; v.dstrb = dstrb;
    v.fgnt = fgnt; v.dgnt = dgnt; v.men = men; v.maddr = maddr; v.mwe = mwe;
    v.frv = frv; v.frd = frd; v.drv = drv; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic freq, input logic [31:0] faddr, input logic fflush,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [3:0] dstrb);
    fetch_req = freq; fetch_addr = faddr; fetch_flush = fflush;
    data_req = dreq; data_we = dwe; data_addr = daddr;
    data_wdata = dwdata; data_wstrb = dstrb;
  endtask

  vec_t vt [19];

  initial begin
    // Response columns (frv/frd/drv/drd) reflect the previous row's access.
    vt[0]  = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 1,32'hA500_0004, 0,32'h0);
    vt[1]  = mk(0, 32'h0,     0, 1, 1, 32'h20,    32'hDEAD_BEEF,4'hF, 0,1,1, 15'd8,4'hF, 0,32'hA500_0004, 0,32'h0);
    vt[2]  = mk(1, 32'h20,    0, 0, 0, 32'h0,     32'h0,        4'h0, 1,0,1, 15'd8,4'h0, 0,32'hA500_0004, 0,32'h0);
    vt[3]  = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 1,32'hDEAD_BEEF, 0,32'h0);
    vt[4]  = mk(0, 32'h0,     0, 1, 0, 32'h8,     32'h0,        4'h0, 0,1,1, 15'd2,4'h0, 0,32'hDEAD_BEEF, 0,32'h0);
    vt[5]  = mk(0, 32'h0,     1, 1, 0, 32'h20004, 32'h0,        4'h0, 0,1,1, 15'd1,4'h0, 0,32'hDEAD_BEEF, 1,32'hA500_0002);
    vt[6]  = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 0,32'hDEAD_BEEF, 1,32'hA500_0001);
    vt[7]  = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 0,32'hDEAD_BEEF, 0,32'hA500_0001);
    vt[8]  = mk(0, 32'h0,     0, 1, 1, 32'h20,    32'h1111_1111,4'h0, 0,1,1, 15'd8,4'h0, 0,32'hDEAD_BEEF, 0,32'hA500_0001);
    vt[9]  = mk(0, 32'h0,     0, 1, 1, 32'h24,    32'h0000_CAFE,4'h3, 0,1,1, 15'd9,4'h3, 0,32'hDEAD_BEEF, 0,32'hA500_0001);
    vt[10] = mk(1, 32'h20,    0, 0, 0, 32'h0,     32'h0,        4'h0, 1,0,1, 15'd8,4'h0, 0,32'hDEAD_BEEF, 0,32'hA500_0001);
    vt[11] = mk(1, 32'h24,    0, 0, 0, 32'h0,     32'h0,        4'h0, 1,0,1, 15'd9,4'h0, 1,32'hDEAD_BEEF, 0,32'hA500_0001);
    vt[12] = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 1,32'hA500_CAFE, 0,32'hA500_0001);
    vt[13] = mk(1, 32'h10,    1, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 0,32'hA500_CAFE, 0,32'hA500_0001);
    vt[14] = mk(1, 32'h10,    0, 0, 0, 32'h0,     32'h0,        4'h0, 1,0,1, 15'd4,4'h0, 0,32'hA500_CAFE, 0,32'hA500_0001);
    vt[15] = mk(0, 32'h0,     1, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 0,32'hA500_CAFE, 0,32'hA500_0001);
    vt[16] = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 0,32'hA500_CAFE, 0,32'hA500_0001);
    vt[17] = mk(1, 32'h10,    1, 1, 0, 32'h8,     32'h0,        4'h0, 0,1,1, 15'd2,4'h0, 0,32'hA500_CAFE, 0,32'hA500_0001);
    vt[18] = mk(0, 32'h0,     0, 0, 0, 32'h0,     32'h0,        4'h0, 0,0,0, 15'd0,4'h0, 0,32'hA500_CAFE, 1,32'hA500_0002);

    // Reset held with a live fetch request: the port must stay silent.
    rst = 1'b0;
    drive(1, 32'h10, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rst%0d fetch_gnt", c), 32'(fetch_gnt), 32'd0);
      chk($sformatf("rst%0d mem_en", c), 32'(mem_en), 32'd0);
      chk($sformatf("rst%0d mem_addr", c), 32'(mem_addr), 32'd0);
      chk($sformatf("rst%0d fetch_rdata", c), fetch_rdata, 32'd0);
    end
    chk("rst fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst data_rdata", data_rdata, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release fetch_gnt", 32'(fetch_gnt), 32'd1);
    chk("release mem_en", 32'(mem_en), 32'd1);
    chk("release mem_addr", 32'(mem_addr), 32'd4);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vt[i].freq, vt[i].faddr, vt[i].fflush, vt[i].dreq, vt[i].dwe,
            vt[i].daddr, vt[i].dwdata, vt[i].dstrb);
      #1;
      chk($sformatf("row%0d fetch_gnt", i), 32'(fetch_gnt), 32'(vt[i].fgnt));
      chk($sformatf("row%0d data_gnt", i), 32'(data_gnt), 32'(vt[i].dgnt));
      chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vt[i].men));
      if (vt[i].men) begin
        chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].maddr));
        chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vt[i].mwe));
      end
      if (vt[i].dreq && vt[i].dwe)
        chk($sformatf("row%0d mem_wdata", i), mem_wdata, vt[i].dwdata);
      chk($sformatf("row%0d fetch_rvalid", i), 32'(fetch_rvalid), 32'(vt[i].frv));
      chk($sformatf("row%0d fetch_rdata", i), fetch_rdata, vt[i].frd);
      chk($sformatf("row%0d data_rvalid", i), 32'(data_rvalid), 32'(vt[i].drv));
      chk($sformatf("row%0d data_rdata", i), data_rdata, vt[i].drd);
    end

    // Contention for 6 cycles; the last grant before this was to data.
    for (int c = 0; c < 6; c++) begin
      logic ef;
`ifdef IMEM_ARB_RR_EN
      ef = (c % 2 == 0);
`else
      ef = 1'b0;
`endif
      @(negedge clk);
      drive(1, 32'h10, 0, 1, 0, 32'h8, 32'h0, 4'h0);
      #1;
      chk($sformatf("tie%0d fetch_gnt", c), 32'(fetch_gnt), 32'(ef));
      chk($sformatf("tie%0d data_gnt", c), 32'(data_gnt), 32'(!ef));
    end

    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Reset lands on the response cycle of a data read.
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 0, 32'h8, 32'h0, 4'h0);
    #1;
    chk("rstrd data_gnt", 32'(data_gnt), 32'd1);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    #1;
    chk("rstrd data_rvalid", 32'(data_rvalid), 32'd0);
    chk("rstrd data_rdata", data_rdata, 32'd0);
    chk("rstrd fetch_rdata", fetch_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("post%0d data_rvalid", c), 32'(data_rvalid), 32'd0);
      chk($sformatf("post%0d fetch_rvalid", c), 32'(fetch_rvalid), 32'd0);
      chk($sformatf("post%0d data_rdata", c), data_rdata, 32'd0);
      chk($sformatf("post%0d fetch_rdata", c), fetch_rdata, 32'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
